pulse_generator: RTL and testbench

Programmable periodic strobe generator. A down-counter produces a single-cycle high pulse every (divisor+1) enabled clock cycles. It is used as a clock-enable or tick source for slower logic, such as baud and timer ticks, inside the single clock domain.

---
 rtl/pulse_generator.sv | 39 +++
 tb/tb_pulse_generator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_generator.sv
// Periodic single-cycle strobe: one pulse every (divisor+1) enabled clk cycles.
// Latency: the pulse is registered and high in the cycle after the edge that finds count == 0.
// Backpressure: none; a low enable freezes the countdown and suppresses pulses.
module pulse_generator #(
    parameter int Width          = 8,
    parameter int InitialDivisor = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [Width-1:0] divisor,
    output logic             pulse_out
);

    localparam logic [Width-1:0] InitCount = Width'(InitialDivisor);
    localparam logic [Width-1:0] CountOne  = Width'(1);

    logic [Width-1:0] count;

    // The reload is taken at the zero crossing, so count never goes below 0.
    // A divisor change therefore only lands at the next reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= InitCount;
            pulse_out <= 1'b0;
        end else if (enable) begin
            if (count == '0) begin
                pulse_out <= 1'b1;
                count     <= divisor;
            end else begin
                pulse_out <= 1'b0;
                count     <= count - CountOne;
            end
        end else begin
            pulse_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator with Width=4, InitialDivisor=3.
module tb_pulse_generator;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] divisor;
    logic       pulse_out;

    int total = 0;
    int bad   = 0;

    pulse_generator #(
        .Width          (4),
        .InitialDivisor (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .divisor   (divisor),
        .pulse_out (pulse_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge and settle 1ns past it before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Enter reset between edges, hold for two edges, release between edges with enable low.
    task automatic apply_reset;
        enable = 1'b0;
        rst    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        enable  = 1'b0;
        divisor = 4'd3;
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (pulse_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got %b want 0", pulse_out);
        end
        tick();
        tick();
        total++;
        if (pulse_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got %b want 0", pulse_out);
        end
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (pulse_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle edge %0d: got %b want 0", k, pulse_out);
            end
        end
    endtask

    task automatic test_periodic;
        logic exp;
        apply_reset();
        divisor = 4'd3;
        enable  = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp = (k % 4 == 0);
            total++;
            if (pulse_out !== exp) begin
                bad++;
                $display("FAIL periodic edge %0d: got %b want %b", k, pulse_out, exp);
            end
        end
    endtask

    task automatic test_enable_hold;
        logic exp;
        apply_reset();
        divisor = 4'd3;
        enable  = 1'b1;
        // Edges 1,2 leave count at 1; edges 3,4 are disabled; pulse follows on edge 6.
        for (int k = 1; k <= 11; k++) begin
            enable = !(k == 3 || k == 4);
            tick();
            exp = (k == 6 || k == 10);
            total++;
            if (pulse_out !== exp) begin
                bad++;
                $display("FAIL enable_hold edge %0d: got %b want %b", k, pulse_out, exp);
            end
        end
    endtask

    task automatic test_div_zero;
        logic exp;
        apply_reset();
        divisor = 4'd0;
        enable  = 1'b1;
        // Pulse continuous from edge 4, enable low on edges 9,10, back on from edge 11.
        for (int k = 1; k <= 13; k++) begin
            enable = !(k == 9 || k == 10);
            tick();
            exp = (k >= 4) && !(k == 9 || k == 10);
            total++;
            if (pulse_out !== exp) begin
                bad++;
                $display("FAIL div_zero edge %0d: got %b want %b", k, pulse_out, exp);
            end
        end
    endtask

    task automatic test_max_div;
        logic exp;
        apply_reset();
        divisor = 4'd15;
        enable  = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            tick();
            exp = (k == 4 || k == 20 || k == 36);
            total++;
            if (pulse_out !== exp) begin
                bad++;
                $display("FAIL max_div edge %0d: got %b want %b", k, pulse_out, exp);
            end
        end
    endtask

    task automatic test_div_change;
        logic exp;
        apply_reset();
        divisor = 4'd3;
        enable  = 1'b1;
        // Reload at edge 4 takes 3; switching to 1 after edge 5 waits for the edge-8 reload.
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 5) divisor = 4'd1;
            exp = (k == 4) || (k >= 8 && k % 2 == 0);
            total++;
            if (pulse_out !== exp) begin
                bad++;
                $display("FAIL div_change edge %0d: got %b want %b", k, pulse_out, exp);
            end
        end
    endtask

    task automatic test_async_reset;
        logic exp;
        apply_reset();
        divisor = 4'd3;
        enable  = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        total++;
        if (pulse_out !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_pulse: got %b want 1", pulse_out);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (pulse_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_pulse_reset: got %b want 0", pulse_out);
        end
        tick();
        tick();
        total++;
        if (pulse_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_held_enabled: got %b want 0", pulse_out);
        end
        rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp = (k == 4 || k == 8);
            total++;
            if (pulse_out !== exp) begin
                bad++;
                $display("FAIL after_reset edge %0d: got %b want %b", k, pulse_out, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_enable_hold();
        test_div_zero();
        test_max_div();
        test_div_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
